// File: rtl/fb_arb_pkg.sv
// Shared types and constants for the frame buffer read arbiter.
package fb_arb_pkg;

  localparam int PIX_W = 12;

  typedef enum logic [1:0] {
    DISPLAY = 2'd0,
    DRAIN_P = 2'd1,
    PROCESS = 2'd2,
    DRAIN_D = 2'd3
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_VGA  = 2'd1,
    OWN_PROC = 2'd2
  } own_tag_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v, input logic en);
    return (en && (v != 16'hFFFF)) ? (v + 16'd1) : v;
  endfunction

endpackage

// File: rtl/fb_rd_tag_pipe.sv
// Owner-tag delay line matching the frame buffer read latency; steers the
// returning pixel to whichever requester issued the read RD_LAT cycles earlier.
module fb_rd_tag_pipe
  import fb_arb_pkg::*;
#(
  parameter int RD_LAT = 2
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  own_tag_e         push_tag_i,
  input  logic [PIX_W-1:0] mem_rdata_i,
  output logic [PIX_W-1:0] vga_rdata_o,
  output logic             vga_rvalid_o,
  output logic [PIX_W-1:0] proc_rdata_o,
  output logic             proc_rvalid_o
);

  own_tag_e         tag_q [RD_LAT];
  logic [PIX_W-1:0] vga_rdata_q;
  logic [PIX_W-1:0] vga_rdata_d;
  logic [PIX_W-1:0] proc_rdata_q;
  logic [PIX_W-1:0] proc_rdata_d;
  logic             vga_hit;
  logic             proc_hit;

  // The oldest tag lines up with the pixel now on mem_rdata; reset drops it.
  always_comb begin
    vga_hit  = ~reset_i & (tag_q[RD_LAT-1] == OWN_VGA);
    proc_hit = ~reset_i & (tag_q[RD_LAT-1] == OWN_PROC);
    if (vga_hit) begin
      vga_rdata_d = mem_rdata_i;
    end else begin
      vga_rdata_d = vga_rdata_q;
    end
    if (proc_hit) begin
      proc_rdata_d = mem_rdata_i;
    end else begin
      proc_rdata_d = proc_rdata_q;
    end
  end

  assign vga_rvalid_o  = vga_hit;
  assign proc_rvalid_o = proc_hit;
  assign vga_rdata_o   = vga_rdata_d;
  assign proc_rdata_o  = proc_rdata_d;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < RD_LAT; i++) begin
        tag_q[i] <= OWN_NONE;
      end
      vga_rdata_q  <= {PIX_W{1'b0}};
      proc_rdata_q <= {PIX_W{1'b0}};
    end else begin
      tag_q[0] <= push_tag_i;
      for (int i = 1; i < RD_LAT; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
      vga_rdata_q  <= vga_rdata_d;
      proc_rdata_q <= proc_rdata_d;
    end
  end

endmodule

// File: rtl/fb_read_arbiter.sv
// Frame buffer port-B arbiter between video playback and image processing.
// Optional FB_ARB_STATS_EN adds saturating miss/grant counters.
module fb_read_arbiter
  import fb_arb_pkg::*;
#(
  parameter int RD_LAT = 2,
  parameter int AW     = 19
) (
  input  logic             clk_25mhz,
  input  logic             reset,
  input  logic             image_start,
  input  logic             image_done,
  input  logic             vga_req,
  input  logic [AW-1:0]    vga_addr,
  output logic [PIX_W-1:0] vga_rdata,
  output logic             vga_rvalid,
  output logic             vga_miss,
  input  logic             proc_req,
  input  logic [AW-1:0]    proc_addr,
  output logic             proc_gnt,
  output logic [PIX_W-1:0] proc_rdata,
  output logic             proc_rvalid,
  output logic [AW-1:0]    mem_addr,
  input  logic [PIX_W-1:0] mem_rdata,
  output logic [1:0]       mode
`ifdef FB_ARB_STATS_EN
  ,
  output logic [15:0]      vga_miss_cnt,
  output logic [15:0]      proc_gnt_cnt
`endif
);

  localparam logic [2:0] DRAIN_LAST = 3'(RD_LAT - 1);

  arb_state_e    state_q;
  arb_state_e    state_d;
  logic [2:0]    drain_cnt_q;
  logic [2:0]    drain_cnt_d;
  logic [AW-1:0] mem_addr_q;
  logic [AW-1:0] mem_addr_d;
  logic          vga_win;
  logic          proc_win;
  logic          vga_gnt;
  own_tag_e      push_tag;

  // Mode sequencing and per-mode priority; drains grant nobody.
  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    vga_win     = 1'b0;
    proc_win    = 1'b0;
    case (state_q)
      DISPLAY: begin
        vga_win  = vga_req;
        proc_win = proc_req & ~vga_req;
        if (image_start && !image_done) begin
          state_d     = DRAIN_P;
          drain_cnt_d = 3'd0;
        end else begin
          state_d = DISPLAY;
        end
      end
      DRAIN_P: begin
        if (drain_cnt_q == DRAIN_LAST) begin
          state_d     = PROCESS;
          drain_cnt_d = 3'd0;
        end else begin
          drain_cnt_d = drain_cnt_q + 3'd1;
        end
      end
      PROCESS: begin
        proc_win = proc_req;
        vga_win  = vga_req & ~proc_req;
        if (image_done || !image_start) begin
          state_d     = DRAIN_D;
          drain_cnt_d = 3'd0;
        end else begin
          state_d = PROCESS;
        end
      end
      DRAIN_D: begin
        if (drain_cnt_q == DRAIN_LAST) begin
          state_d     = DISPLAY;
          drain_cnt_d = 3'd0;
        end else begin
          drain_cnt_d = drain_cnt_q + 3'd1;
        end
      end
      default: begin
        state_d     = DISPLAY;
        drain_cnt_d = 3'd0;
      end
    endcase
  end

  assign vga_gnt  = vga_win & ~reset;
  assign proc_gnt = proc_win & ~reset;
  assign vga_miss = vga_req & ~vga_gnt & ~reset;
  assign mode     = state_q;
  assign mem_addr = mem_addr_d;

  // Address mux holds the last issued address when nobody is granted.
  always_comb begin
    if (vga_gnt) begin
      mem_addr_d = vga_addr;
      push_tag   = OWN_VGA;
    end else if (proc_gnt) begin
      mem_addr_d = proc_addr;
      push_tag   = OWN_PROC;
    end else begin
      mem_addr_d = mem_addr_q;
      push_tag   = OWN_NONE;
    end
  end

  always_ff @(posedge clk_25mhz) begin
    if (reset) begin
      state_q     <= DISPLAY;
      drain_cnt_q <= 3'd0;
      mem_addr_q  <= {AW{1'b0}};
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      mem_addr_q  <= mem_addr_d;
    end
  end

  fb_rd_tag_pipe #(
    .RD_LAT(RD_LAT)
  ) u_tag_pipe (
    .clk_i        (clk_25mhz),
    .reset_i      (reset),
    .push_tag_i   (push_tag),
    .mem_rdata_i  (mem_rdata),
    .vga_rdata_o  (vga_rdata),
    .vga_rvalid_o (vga_rvalid),
    .proc_rdata_o (proc_rdata),
    .proc_rvalid_o(proc_rvalid)
  );

`ifdef FB_ARB_STATS_EN
  logic [15:0] vga_miss_cnt_q;
  logic [15:0] proc_gnt_cnt_q;

  always_ff @(posedge clk_25mhz) begin
    if (reset) begin
      vga_miss_cnt_q <= 16'h0000;
      proc_gnt_cnt_q <= 16'h0000;
    end else begin
      vga_miss_cnt_q <= sat_inc16(vga_miss_cnt_q, vga_miss);
      proc_gnt_cnt_q <= sat_inc16(proc_gnt_cnt_q, proc_gnt);
    end
  end

  assign vga_miss_cnt = vga_miss_cnt_q;
  assign proc_gnt_cnt = proc_gnt_cnt_q;
`endif

endmodule

// File: tb/tb_fb_read_arbiter.sv
// Scoreboard bench for fb_read_arbiter with a latency-accurate frame buffer model.
module tb_fb_read_arbiter;
  import fb_arb_pkg::*;

  localparam int RD_LAT = 2;
  localparam int AW     = 19;

  typedef struct {
    int         due;
    logic       ch;
    logic [11:0] data;
  } ret_t;

  logic          clk_25mhz = 1'b0;
  logic          reset;
  logic          image_start;
  logic          image_done;
  logic          vga_req;
  logic [AW-1:0] vga_addr;
  logic [11:0]   vga_rdata;
  logic          vga_rvalid;
  logic          vga_miss;
  logic          proc_req;
  logic [AW-1:0] proc_addr;
  logic          proc_gnt;
  logic [11:0]   proc_rdata;
  logic          proc_rvalid;
  logic [AW-1:0] mem_addr;
  logic [11:0]   mem_rdata;
  logic [1:0]    mode;
`ifdef FB_ARB_STATS_EN
  logic [15:0]   vga_miss_cnt;
  logic [15:0]   proc_gnt_cnt;
`endif

  logic [AW-1:0] addr_pipe [RD_LAT];
  ret_t          eq[$];
  ret_t          oq[$];
  int            cyc   = 0;
  int            n_cmp = 0;
  int            n_err = 0;

  always #20 clk_25mhz = ~clk_25mhz;

  function automatic logic [11:0] pix_of(input logic [AW-1:0] a);
    return a[11:0] ^ {a[18:12], 5'b10110};
  endfunction

  // Frame buffer port B: data for an address appears RD_LAT cycles later.
  always @(posedge clk_25mhz) begin
    addr_pipe[0] <= mem_addr;
    for (int i = 1; i < RD_LAT; i++) addr_pipe[i] <= addr_pipe[i-1];
  end
  assign mem_rdata = pix_of(addr_pipe[RD_LAT-1]);

  fb_read_arbiter #(.RD_LAT(RD_LAT), .AW(AW)) dut (
    .clk_25mhz  (clk_25mhz),
    .reset      (reset),
    .image_start(image_start),
    .image_done (image_done),
    .vga_req    (vga_req),
    .vga_addr   (vga_addr),
    .vga_rdata  (vga_rdata),
    .vga_rvalid (vga_rvalid),
    .vga_miss   (vga_miss),
    .proc_req   (proc_req),
    .proc_addr  (proc_addr),
    .proc_gnt   (proc_gnt),
    .proc_rdata (proc_rdata),
    .proc_rvalid(proc_rvalid),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .mode       (mode)
`ifdef FB_ARB_STATS_EN
    ,
    .vga_miss_cnt(vga_miss_cnt),
    .proc_gnt_cnt(proc_gnt_cnt)
`endif
  );

  // One clock: drive just after the edge, sample at the falling edge, log returns.
  task automatic cycle(input logic rst, input logic vr, input logic [AW-1:0] va,
                       input logic pr, input logic [AW-1:0] pa,
                       input logic st, input logic dn);
    @(posedge clk_25mhz);
    #1;
    reset = rst; vga_req = vr; vga_addr = va; proc_req = pr; proc_addr = pa;
    image_start = st; image_done = dn;
    cyc++;
    @(negedge clk_25mhz);
    if (vga_rvalid === 1'b1) oq.push_back(ret_t'{due: cyc, ch: 1'b0, data: vga_rdata});
    if (proc_rvalid === 1'b1) oq.push_back(ret_t'{due: cyc, ch: 1'b1, data: proc_rdata});
  endtask

  task automatic test_reset();
    cycle(1'b1, 1'b1, 19'h01234, 1'b1, 19'h00777, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 19'h01234, 1'b1, 19'h00777, 1'b0, 1'b0);
    n_cmp++; if (mode !== 2'd0) begin n_err++; $display("FAIL reset_mode got=%0d exp=0", mode); end
    n_cmp++; if (proc_gnt !== 1'b0) begin n_err++; $display("FAIL reset_proc_gnt got=%b exp=0", proc_gnt); end
    n_cmp++; if (vga_miss !== 1'b0) begin n_err++; $display("FAIL reset_vga_miss got=%b exp=0", vga_miss); end
    n_cmp++; if (mem_addr !== 19'h00000) begin n_err++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); end
    n_cmp++; if ({vga_rvalid, proc_rvalid} !== 2'b00) begin n_err++; $display("FAIL reset_rvalid got=%b%b exp=00", vga_rvalid, proc_rvalid); end
    n_cmp++; if ({vga_rdata, proc_rdata} !== 24'h000000) begin n_err++; $display("FAIL reset_rdata got=%h/%h exp=0/0", vga_rdata, proc_rdata); end
    oq.delete();
    cycle(1'b0, 1'b0, 19'h00000, 1'b0, 19'h00000, 1'b0, 1'b0);
    n_cmp++; if (mode !== 2'd0) begin n_err++; $display("FAIL reset_idle_mode got=%0d exp=0", mode); end
  endtask

  task automatic test_vga_priority();
    ret_t e, o;
    cycle(1'b0, 1'b1, 19'h00010, 1'b1, 19'h00200, 1'b0, 1'b0);
    n_cmp++; if (proc_gnt !== 1'b0) begin n_err++; $display("FAIL prio_proc_gnt got=%b exp=0", proc_gnt); end
    n_cmp++; if (mem_addr !== 19'h00010) begin n_err++; $display("FAIL prio_mem_addr got=%h exp=00010", mem_addr); end
    n_cmp++; if (vga_miss !== 1'b0) begin n_err++; $display("FAIL prio_vga_miss got=%b exp=0", vga_miss); end
    eq.push_back(ret_t'{due: cyc + RD_LAT, ch: 1'b0, data: pix_of(19'h00010)});
    cycle(1'b0, 1'b0, 19'h00999, 1'b0, 19'h00200, 1'b0, 1'b0);
    n_cmp++; if (mem_addr !== 19'h00010) begin n_err++; $display("FAIL prio_addr_hold got=%h exp=00010", mem_addr); end
    repeat (3) cycle(1'b0, 1'b0, 19'h00000, 1'b0, 19'h00000, 1'b0, 1'b0);
    while (eq.size() > 0 || oq.size() > 0) begin
      n_cmp++;
      if (eq.size() == 0 || oq.size() == 0) begin
        n_err++; $display("FAIL prio_return_count got_left=%0d exp_left=%0d", oq.size(), eq.size());
        eq.delete(); oq.delete();
      end else begin
        e = eq.pop_front(); o = oq.pop_front();
        if (o.due != e.due || o.ch !== e.ch || o.data !== e.data) begin
          n_err++; $display("FAIL prio_return got cyc=%0d ch=%0d data=%h exp cyc=%0d ch=%0d data=%h", o.due, o.ch, o.data, e.due, e.ch, e.data);
        end
      end
    end
  endtask

  task automatic test_proc_fill();
    ret_t e, o;
    logic [AW-1:0] pa;
    cycle(1'b0, 1'b1, 19'h04321, 1'b1, 19'h10001, 1'b0, 1'b0);
    n_cmp++; if (proc_gnt !== 1'b0) begin n_err++; $display("FAIL fill_first_proc_gnt got=%b exp=0", proc_gnt); end
    eq.push_back(ret_t'{due: cyc + RD_LAT, ch: 1'b0, data: pix_of(19'h04321)});
    for (int i = 0; i < 3; i++) begin
      pa = (i == 2) ? 19'h7FFFF : (19'h10001 + 19'(i));
      cycle(1'b0, 1'b0, 19'h04321, 1'b1, pa, 1'b0, 1'b0);
      n_cmp++; if (proc_gnt !== 1'b1) begin n_err++; $display("FAIL fill_proc_gnt%0d got=%b exp=1", i, proc_gnt); end
      n_cmp++; if (mem_addr !== pa) begin n_err++; $display("FAIL fill_mem_addr%0d got=%h exp=%h", i, mem_addr, pa); end
      eq.push_back(ret_t'{due: cyc + RD_LAT, ch: 1'b1, data: pix_of(pa)});
    end
    cycle(1'b0, 1'b1, 19'h00555, 1'b1, 19'h7FFFF, 1'b0, 1'b0);
    n_cmp++; if (proc_gnt !== 1'b0 || mem_addr !== 19'h00555) begin n_err++; $display("FAIL fill_vga_back got gnt=%b addr=%h exp gnt=0 addr=00555", proc_gnt, mem_addr); end
    n_cmp++; if (vga_rdata !== pix_of(19'h04321)) begin n_err++; $display("FAIL fill_vga_rdata_hold got=%h exp=%h", vga_rdata, pix_of(19'h04321)); end
    eq.push_back(ret_t'{due: cyc + RD_LAT, ch: 1'b0, data: pix_of(19'h00555)});
    repeat (3) cycle(1'b0, 1'b0, 19'h00000, 1'b0, 19'h00000, 1'b0, 1'b0);
    n_cmp++; if (proc_rdata !== pix_of(19'h7FFFF)) begin n_err++; $display("FAIL fill_proc_rdata_hold got=%h exp=%h", proc_rdata, pix_of(19'h7FFFF)); end
    while (eq.size() > 0 || oq.size() > 0) begin
      n_cmp++;
      if (eq.size() == 0 || oq.size() == 0) begin
        n_err++; $display("FAIL fill_return_count got_left=%0d exp_left=%0d", oq.size(), eq.size());
        eq.delete(); oq.delete();
      end else begin
        e = eq.pop_front(); o = oq.pop_front();
        if (o.due != e.due || o.ch !== e.ch || o.data !== e.data) begin
          n_err++; $display("FAIL fill_return got cyc=%0d ch=%0d data=%h exp cyc=%0d ch=%0d data=%h", o.due, o.ch, o.data, e.due, e.ch, e.data);
        end
      end
    end
  endtask

  task automatic test_mode_switch();
    ret_t e, o;
    cycle(1'b0, 1'b1, 19'h00AAA, 1'b1, 19'h0BBB0, 1'b1, 1'b0);
    n_cmp++; if (mode !== 2'd0 || proc_gnt !== 1'b0) begin n_err++; $display("FAIL sw_start got mode=%0d gnt=%b exp mode=0 gnt=0", mode, proc_gnt); end
    eq.push_back(ret_t'{due: cyc + RD_LAT, ch: 1'b0, data: pix_of(19'h00AAA)});
    for (int k = 0; k < 2; k++) begin
      cycle(1'b0, 1'b1, 19'h00ABC, 1'b1, 19'h0BBB0, 1'b1, 1'b0);
      n_cmp++; if (mode !== 2'd1) begin n_err++; $display("FAIL sw_drain_mode%0d got=%0d exp=1", k, mode); end
      n_cmp++; if (proc_gnt !== 1'b0 || vga_miss !== 1'b1) begin n_err++; $display("FAIL sw_drain_gnt%0d got gnt=%b miss=%b exp gnt=0 miss=1", k, proc_gnt, vga_miss); end
      n_cmp++; if (mem_addr !== 19'h00AAA) begin n_err++; $display("FAIL sw_drain_addr%0d got=%h exp=00AAA", k, mem_addr); end
    end
    cycle(1'b0, 1'b1, 19'h00ABC, 1'b1, 19'h0BBB0, 1'b1, 1'b0);
    n_cmp++; if (mode !== 2'd2 || proc_gnt !== 1'b1 || vga_miss !== 1'b1) begin n_err++; $display("FAIL sw_process got mode=%0d gnt=%b miss=%b exp 2/1/1", mode, proc_gnt, vga_miss); end
    eq.push_back(ret_t'{due: cyc + RD_LAT, ch: 1'b1, data: pix_of(19'h0BBB0)});
    cycle(1'b0, 1'b1, 19'h00ABD, 1'b0, 19'h0BBB0, 1'b1, 1'b0);
    n_cmp++; if (vga_miss !== 1'b0 || mem_addr !== 19'h00ABD) begin n_err++; $display("FAIL sw_vga_in_process got miss=%b addr=%h exp 0/00ABD", vga_miss, mem_addr); end
    eq.push_back(ret_t'{due: cyc + RD_LAT, ch: 1'b0, data: pix_of(19'h00ABD)});
    repeat (3) cycle(1'b0, 1'b0, 19'h00000, 1'b0, 19'h00000, 1'b1, 1'b0);
    while (eq.size() > 0 || oq.size() > 0) begin
      n_cmp++;
      if (eq.size() == 0 || oq.size() == 0) begin
        n_err++; $display("FAIL sw_return_count got_left=%0d exp_left=%0d", oq.size(), eq.size());
        eq.delete(); oq.delete();
      end else begin
        e = eq.pop_front(); o = oq.pop_front();
        if (o.due != e.due || o.ch !== e.ch || o.data !== e.data) begin
          n_err++; $display("FAIL sw_return got cyc=%0d ch=%0d data=%h exp cyc=%0d ch=%0d data=%h", o.due, o.ch, o.data, e.due, e.ch, e.data);
        end
      end
    end
  endtask

  task automatic test_drain_d();
    ret_t e, o;
    cycle(1'b0, 1'b0, 19'h00000, 1'b1, 19'h22222, 1'b1, 1'b0);
    n_cmp++; if (mode !== 2'd2 || proc_gnt !== 1'b1) begin n_err++; $display("FAIL dd_first got mode=%0d gnt=%b exp 2/1", mode, proc_gnt); end
    eq.push_back(ret_t'{due: cyc + RD_LAT, ch: 1'b1, data: pix_of(19'h22222)});
    cycle(1'b0, 1'b0, 19'h00000, 1'b1, 19'h33333, 1'b1, 1'b1);
    n_cmp++; if (mode !== 2'd2 || proc_gnt !== 1'b1) begin n_err++; $display("FAIL dd_second got mode=%0d gnt=%b exp 2/1", mode, proc_gnt); end
    eq.push_back(ret_t'{due: cyc + RD_LAT, ch: 1'b1, data: pix_of(19'h33333)});
    for (int k = 0; k < 2; k++) begin
      cycle(1'b0, 1'b1, 19'h00F00, 1'b1, 19'h44444, 1'b1, 1'b1);
      n_cmp++; if (mode !== 2'd3 || proc_gnt !== 1'b0 || vga_miss !== 1'b1) begin n_err++; $display("FAIL dd_drain%0d got mode=%0d gnt=%b miss=%b exp 3/0/1", k, mode, proc_gnt, vga_miss); end
    end
    cycle(1'b0, 1'b0, 19'h00000, 1'b0, 19'h00000, 1'b0, 1'b0);
    n_cmp++; if (mode !== 2'd0) begin n_err++; $display("FAIL dd_display got=%0d exp=0", mode); end
    while (eq.size() > 0 || oq.size() > 0) begin
      n_cmp++;
      if (eq.size() == 0 || oq.size() == 0) begin
        n_err++; $display("FAIL dd_return_count got_left=%0d exp_left=%0d", oq.size(), eq.size());
        eq.delete(); oq.delete();
      end else begin
        e = eq.pop_front(); o = oq.pop_front();
        if (o.due != e.due || o.ch !== e.ch || o.data !== e.data) begin
          n_err++; $display("FAIL dd_return got cyc=%0d ch=%0d data=%h exp cyc=%0d ch=%0d data=%h", o.due, o.ch, o.data, e.due, e.ch, e.data);
        end
      end
    end
  endtask

  task automatic test_drain_reverse();
    logic [1:0] em;
    cycle(1'b0, 1'b0, 19'h00000, 1'b0, 19'h00000, 1'b1, 1'b0);
    n_cmp++; if (mode !== 2'd0) begin n_err++; $display("FAIL rev_start got=%0d exp=0", mode); end
    for (int k = 0; k < 6; k++) begin
      cycle(1'b0, 1'b0, 19'h00000, 1'b0, 19'h00000, 1'b0, 1'b0);
      case (k)
        0, 1:    em = 2'd1;
        2:       em = 2'd2;
        3, 4:    em = 2'd3;
        default: em = 2'd0;
      endcase
      n_cmp++; if (mode !== em) begin n_err++; $display("FAIL rev_mode%0d got=%0d exp=%0d", k, mode, em); end
    end
  endtask

  task automatic test_reset_flush();
    oq.delete();
    cycle(1'b0, 1'b0, 19'h00000, 1'b0, 19'h00000, 1'b1, 1'b0);
    repeat (2) cycle(1'b0, 1'b0, 19'h00000, 1'b0, 19'h00000, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 19'h01234, 1'b0, 19'h00000, 1'b1, 1'b0);
    n_cmp++; if (mode !== 2'd2 || vga_miss !== 1'b0 || mem_addr !== 19'h01234) begin n_err++; $display("FAIL flush_grant got mode=%0d miss=%b addr=%h exp 2/0/01234", mode, vga_miss, mem_addr); end
    cycle(1'b1, 1'b0, 19'h00000, 1'b0, 19'h00000, 1'b0, 1'b0);
    repeat (4) cycle(1'b0, 1'b0, 19'h00000, 1'b0, 19'h00000, 1'b0, 1'b0);
    n_cmp++; if (oq.size() != 0) begin n_err++; $display("FAIL flush_no_rvalid got=%0d returns exp=0", oq.size()); end
    n_cmp++; if (mode !== 2'd0) begin n_err++; $display("FAIL flush_mode got=%0d exp=0", mode); end
    n_cmp++; if (vga_rdata !== 12'h000) begin n_err++; $display("FAIL flush_vga_rdata got=%h exp=000", vga_rdata); end
    oq.delete();
  endtask

`ifdef FB_ARB_STATS_EN
  task automatic test_stats();
    cycle(1'b1, 1'b0, 19'h00000, 1'b0, 19'h00000, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 19'h00000, 1'b0, 19'h00000, 1'b0, 1'b0);
    n_cmp++; if (vga_miss_cnt !== 16'h0000 || proc_gnt_cnt !== 16'h0000) begin n_err++; $display("FAIL stats_clear got=%h/%h exp=0000/0000", vga_miss_cnt, proc_gnt_cnt); end
    cycle(1'b0, 1'b0, 19'h00000, 1'b0, 19'h00000, 1'b1, 1'b0);
    repeat (2) cycle(1'b0, 1'b1, 19'h00100, 1'b0, 19'h00000, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 19'h00100, 1'b1, 19'h00200, 1'b1, 1'b0);
    n_cmp++; if (vga_miss_cnt !== 16'h0002 || proc_gnt_cnt !== 16'h0000) begin n_err++; $display("FAIL stats_count got=%h/%h exp=0002/0000", vga_miss_cnt, proc_gnt_cnt); end
    repeat (70000) cycle(1'b0, 1'b1, 19'h00100, 1'b1, 19'h00200, 1'b1, 1'b0);
    n_cmp++; if (vga_miss_cnt !== 16'hFFFF || proc_gnt_cnt !== 16'hFFFF) begin n_err++; $display("FAIL stats_sat got=%h/%h exp=FFFF/FFFF", vga_miss_cnt, proc_gnt_cnt); end
    repeat (5) cycle(1'b0, 1'b1, 19'h00100, 1'b1, 19'h00200, 1'b1, 1'b0);
    n_cmp++; if (vga_miss_cnt !== 16'hFFFF || proc_gnt_cnt !== 16'hFFFF) begin n_err++; $display("FAIL stats_hold got=%h/%h exp=FFFF/FFFF", vga_miss_cnt, proc_gnt_cnt); end
    oq.delete();
  endtask
`endif

  initial begin
    reset = 1'b1; image_start = 1'b0; image_done = 1'b0;
    vga_req = 1'b0; vga_addr = 19'h00000; proc_req = 1'b0; proc_addr = 19'h00000;
    test_reset();
    test_vga_priority();
    test_proc_fill();
    test_mode_switch();
    test_drain_d();
    test_drain_reverse();
    test_reset_flush();
`ifdef FB_ARB_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fb_read_arbiter.md
FB_READ_ARBITER -- requirements
Module: fb_read_arbiter

Interface
REQ-001 The block SHALL have parameter RD_LAT, default 2, giving the frame buffer read latency in cycles from address to data (legal range 1-4).
REQ-002 The block SHALL have parameter AW, default 19, the address width; pixel data width is fixed at 12.
REQ-003 The block SHALL have port clk_25mhz, input, 1, the single clock for all logic.
REQ-004 The block SHALL have port reset, input, 1, a synchronous, active-high reset.
REQ-005 The block SHALL have port image_start, input, 1, a level request for processing mode.
REQ-006 The block SHALL have port image_done, input, 1, a level signal that processing is complete.
REQ-007 The block SHALL have ports vga_req (in, 1), vga_addr (in, AW), vga_rdata (out, 12), vga_rvalid (out, 1) and vga_miss (out, 1) for the video playback requester.
REQ-008 The block SHALL have ports proc_req (in, 1), proc_addr (in, AW), proc_gnt (out, 1), proc_rdata (out, 12) and proc_rvalid (out, 1) for the image processing requester.
REQ-009 The block SHALL have ports mem_addr (out, AW) and mem_rdata (in, 12) connecting to frame buffer port B, which is always enabled.
REQ-010 The block SHALL have port mode, output, 2, the current state encoding.

Function
REQ-011 The block SHALL implement states DISPLAY=0, DRAIN_P=1, PROCESS=2 and DRAIN_D=3.
REQ-012 DISPLAY SHALL transition to DRAIN_P when image_start=1 and image_done=0.
REQ-013 PROCESS SHALL transition to DRAIN_D when image_done=1 or image_start=0.
REQ-014 DRAIN_P and DRAIN_D SHALL each last exactly RD_LAT cycles and then enter PROCESS or DISPLAY respectively; no grant of either requester SHALL occur during a drain.
REQ-015 In DISPLAY, vga_req SHALL always win, and proc_gnt=proc_req&~vga_req.
REQ-016 In PROCESS, proc_req SHALL always win, and a VGA grant SHALL equal vga_req&~proc_req.
REQ-017 vga_miss SHALL be high in any cycle where vga_req=1 and VGA is not granted.
REQ-018 mem_addr SHALL be combinational: the granted requester's address, else the previous mem_addr held in a register.
REQ-019 proc_gnt SHALL be combinational in the request cycle; the processor holds proc_req and proc_addr stable until it sees proc_gnt=1.
REQ-020 Each grant SHALL push an owner tag (none/VGA/proc) into an RD_LAT-deep shift register.
REQ-021 The matching rvalid SHALL pulse exactly RD_LAT cycles after the grant cycle, with rdata=mem_rdata; the non-matching rdata SHALL hold its last value.
REQ-022 Back-to-back grants SHALL sustain one read per cycle with in-order returns.
REQ-023 If a mode condition reverses during a drain, the drain SHALL still complete before it is re-evaluated.

Reset
REQ-024 On reset, the state SHALL become DISPLAY, all tags SHALL become none, the drain counter SHALL be 0, and rvalid, proc_gnt and vga_miss SHALL be 0.
REQ-025 On reset, rdata outputs and mem_addr SHALL be 0.
REQ-026 Reads in flight at reset SHALL be discarded, with no rvalid for them.

Configuration
REQ-027 With macro FB_ARB_STATS_EN defined, the block SHALL add outputs vga_miss_cnt[15:0] and proc_gnt_cnt[15:0].
REQ-028 These counters SHALL saturate at 16'hFFFF and clear on reset.
REQ-029 Without FB_ARB_STATS_EN, the counter ports and logic SHALL be absent, and behaviour SHALL otherwise be identical.

Structure
REQ-030 Package fb_arb_pkg SHALL hold the state enum, the owner-tag enum (OWN_NONE, OWN_VGA, OWN_PROC) and the 12-bit pixel width constant.
REQ-031 Sub-module fb_rd_tag_pipe SHALL hold the RD_LAT tag shift register and the rvalid/rdata steering; the arbitration FSM SHALL stay in fb_read_arbiter.

Verification
REQ-032 Test: reset, vga_req=1 with vga_addr=0x00010, proc_req=1 -> proc_gnt=0, mem_addr=0x00010, and vga_rvalid=1 at cycle +2.
REQ-033 Test: in DISPLAY, drop vga_req for 3 cycles with proc_req=1 -> proc_gnt=1 for those 3 cycles, and 3 proc_rvalid pulses in order at latency 2.
REQ-034 Test: raise image_start=1 -> mode goes 0->1 for 2 cycles ->2, no grants in mode 1, and vga_miss=1 while vga_req=1.
REQ-035 Test: in PROCESS, assert image_done with 2 proc reads in flight -> both proc_rvalid pulses return correctly during DRAIN_D, then mode=0.
REQ-036 Test: assert reset with a VGA read in flight -> no vga_rvalid follows, and mode=0.
REQ-037 Test (FB_ARB_STATS_EN): 70000 cycles of VGA misses -> vga_miss_cnt=16'hFFFF, holding at that value.
